// File: rtl/rv_timer_tick_core.sv
// rv_timer_tick_core: prescaled tick generator, mtime increment and
// compare/interrupt logic sitting directly behind the rv_timer register block.
// The register block owns mtime, so this core only proposes next values and
// set strobes, and keeps a single registered copy of the interrupt line.
module rv_timer_tick_core #(
  parameter int PRESCALE_W = 12,
  parameter int STEP_W     = 8,
  parameter int CNT_W      = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  active_i,
  input  logic [PRESCALE_W-1:0] prescaler_i,
  input  logic [STEP_W-1:0]     step_i,
  input  logic [CNT_W-1:0]      mtime_i,
  input  logic [CNT_W-1:0]      mtimecmp_i,
  input  logic                  intr_enable_i,
  input  logic                  intr_state_i,
  input  logic                  intr_test_qe_i,
  input  logic                  intr_test_q_i,
  output logic                  tick_o,
  output logic                  mtime_we_o,
  output logic [CNT_W-1:0]      mtime_d_o,
  output logic                  intr_state_de_o,
  output logic                  intr_state_d_o,
  output logic                  intr_o
);

  logic [PRESCALE_W-1:0] tick_cnt;
  logic                  intr_q;
  logic                  cmp_hit;

  // Tick fires once the count has reached the prescale value; using >= means
  // lowering the prescaler below the running count ticks immediately instead
  // of letting the counter run up to wrap-around.
  always_comb begin
    tick_o = active_i & (tick_cnt >= prescaler_i);
  end

  // Prescale counter: held at zero while inactive, restarts after every tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt <= '0;
    end else if (!active_i || tick_o) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + PRESCALE_W'(1);
    end
  end

  // Next mtime is always offered; the write enable is the tick itself. The
  // sum wraps naturally at 2^CNT_W. A SW write in the same cycle wins inside
  // the register block, and the next tick builds on that written value.
  always_comb begin
    mtime_we_o = tick_o;
    mtime_d_o  = mtime_i + CNT_W'(step_i);
  end

  // Compare is level-sensitive and runs regardless of active_i, so a SW clear
  // while the hit persists is re-set on the following cycle.
  always_comb begin
    cmp_hit         = (mtime_i >= mtimecmp_i);
    intr_state_de_o = cmp_hit | (intr_test_qe_i & intr_test_q_i);
    intr_state_d_o  = 1'b1;
  end

  // Registered interrupt output: no combinational path from the intr inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      intr_q <= 1'b0;
    end else begin
      intr_q <= intr_state_i & intr_enable_i;
    end
  end

  assign intr_o = intr_q;

endmodule

// File: tb/tb_rv_timer_tick_core.sv
// Self-checking bench for rv_timer_tick_core. The reference model counts
// elapsed cycles since activation/last tick as a plain integer and derives all
// outputs from the behavioural rules with ordinary arithmetic.
module tb_rv_timer_tick_core;
  localparam int PW = 12;
  localparam int SW = 8;
  localparam int CW = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          active_i;
  logic [PW-1:0] prescaler_i;
  logic [SW-1:0] step_i;
  logic [CW-1:0] mtime_i;
  logic [CW-1:0] mtimecmp_i;
  logic          intr_enable_i;
  logic          intr_state_i;
  logic          intr_test_qe_i;
  logic          intr_test_q_i;
  logic          tick_o;
  logic          mtime_we_o;
  logic [CW-1:0] mtime_d_o;
  logic          intr_state_de_o;
  logic          intr_state_d_o;
  logic          intr_o;

  int checks = 0;
  int failures = 0;

  // model state
  int m_cycles = 0;     // cycles elapsed since activation or last tick
  bit m_intr = 1'b0;    // interrupt level expected on intr_o
  bit exp_tick;
  bit obs_tick;
  int tick_pos[$];

  always #5 clk_i = ~clk_i;

  rv_timer_tick_core #(.PRESCALE_W(PW), .STEP_W(SW), .CNT_W(CW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .active_i       (active_i),
    .prescaler_i    (prescaler_i),
    .step_i         (step_i),
    .mtime_i        (mtime_i),
    .mtimecmp_i     (mtimecmp_i),
    .intr_enable_i  (intr_enable_i),
    .intr_state_i   (intr_state_i),
    .intr_test_qe_i (intr_test_qe_i),
    .intr_test_q_i  (intr_test_q_i),
    .tick_o         (tick_o),
    .mtime_we_o     (mtime_we_o),
    .mtime_d_o      (mtime_d_o),
    .intr_state_de_o(intr_state_de_o),
    .intr_state_d_o (intr_state_d_o),
    .intr_o         (intr_o)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model for the current input set.
  task automatic check_all(input string tag);
    logic [CW-1:0] exp_d;
    bit exp_de;
    exp_tick = (rst_ni === 1'b1 || 1'b1) && active_i && (m_cycles >= int'(prescaler_i));
    exp_d    = mtime_i + {{(CW-SW){1'b0}}, step_i};
    exp_de   = (mtime_i >= mtimecmp_i) || (intr_test_qe_i && intr_test_q_i);
    obs_tick = tick_o;
    chk1({tag, ".tick"}, tick_o, exp_tick);
    chk1({tag, ".we"}, mtime_we_o, exp_tick);
    chk64({tag, ".mtime_d"}, mtime_d_o, exp_d);
    chk1({tag, ".de"}, intr_state_de_o, exp_de);
    chk1({tag, ".state_d"}, intr_state_d_o, 1'b1);
    chk1({tag, ".intr"}, intr_o, m_intr);
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cyc(input string tag);
    @(negedge clk_i);
    check_all(tag);
    @(posedge clk_i);
    if (!rst_ni) begin
      m_cycles = 0;
      m_intr   = 1'b0;
    end else begin
      m_cycles = (!active_i || exp_tick) ? 0 : m_cycles + 1;
      m_intr   = intr_state_i && intr_enable_i;
    end
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    active_i = 1'b0; prescaler_i = '0; step_i = '0;
    mtime_i = '0; mtimecmp_i = '1;
    intr_enable_i = 1'b0; intr_state_i = 1'b0;
    intr_test_qe_i = 1'b0; intr_test_q_i = 1'b0;

    // reset state
    #2;
    chk1("reset.tick", tick_o, 1'b0);
    chk1("reset.we", mtime_we_o, 1'b0);
    chk1("reset.intr", intr_o, 1'b0);
    cyc("reset");
    rst_ni = 1'b1;
    cyc("post_reset");

    // 1: P=0 ticks every cycle
    active_i = 1'b1; prescaler_i = 0; step_i = 1; mtime_i = 64'd10;
    for (int i = 0; i < 4; i++) begin
      cyc("t1");
      chk1("t1.tick_every", obs_tick, 1'b1);
      chk64("t1.d_eq_11", mtime_d_o, 64'd11);
    end

    // 2: activation with P=3 -> ticks at 3,7,11 after the rise
    active_i = 1'b0;
    cyc("t2_idle");
    prescaler_i = 3; step_i = 2; mtime_i = 64'h100;
    active_i = 1'b1;
    tick_pos.delete();
    for (int i = 0; i < 12; i++) begin
      cyc("t2");
      if (obs_tick) tick_pos.push_back(i);
    end
    checks++;
    assert (tick_pos.size() == 3 && tick_pos[0] == 3 && tick_pos[1] == 7 && tick_pos[2] == 11) else begin
      failures++;
      $error("FAIL t2.tick_positions observed_count=%0d expected=3@{3,7,11}", tick_pos.size());
    end
    chk64("t2.d", mtime_d_o, 64'h102);

    // 3: wrap-around
    prescaler_i = 0; step_i = 1; mtime_i = '1;
    cyc("t3");
    chk64("t3.wrap", mtime_d_o, 64'd0);
    chk1("t3.we", mtime_we_o, 1'b1);

    // 4: compare and interrupt
    active_i = 1'b0; mtimecmp_i = 64'd5; mtime_i = 64'd4;
    cyc("t4_below");
    chk1("t4.de_below", intr_state_de_o, 1'b0);
    mtime_i = 64'd5;
    cyc("t4_equal");
    chk1("t4.de_equal", intr_state_de_o, 1'b1);
    intr_state_i = 1'b1; intr_enable_i = 1'b1;
    cyc("t4_set");
    cyc("t4_intr");
    chk1("t4.intr_o", intr_o, 1'b1);
    intr_state_i = 1'b0; intr_enable_i = 1'b0;
    cyc("t4_clr");
    cyc("t4_low");
    chk1("t4.intr_low", intr_o, 1'b0);

    // default all-ones compare: hit only at all-ones mtime
    mtimecmp_i = '1; mtime_i = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc("cmp_max_below");
    chk1("cmp_max.below", intr_state_de_o, 1'b0);
    mtime_i = '1;
    cyc("cmp_max_hit");
    chk1("cmp_max.hit", intr_state_de_o, 1'b1);
    mtime_i = 64'd0;

    // 5: lower prescaler mid-count, then deactivate mid-count
    prescaler_i = 100; active_i = 1'b1;
    for (int i = 0; i < 50; i++) cyc("t5_run");
    prescaler_i = 20;
    cyc("t5_lower");
    chk1("t5.tick_on_lower", obs_tick, 1'b1);
    prescaler_i = 100;
    cyc("t5_after");
    chk1("t5.no_tick_after", obs_tick, 1'b0);
    for (int i = 0; i < 10; i++) cyc("t5_run2");
    active_i = 1'b0;
    cyc("t5_off");
    chk1("t5.off_no_tick", obs_tick, 1'b0);
    active_i = 1'b1; prescaler_i = 1;
    cyc("t5_restart");
    chk1("t5.restart_cnt0", obs_tick, 1'b0);
    cyc("t5_restart_tick");
    chk1("t5.restart_tick", obs_tick, 1'b1);

    // 6: intr_test strobe, then async reset mid-count
    mtimecmp_i = '1; mtime_i = 64'd7;
    intr_test_qe_i = 1'b1; intr_test_q_i = 1'b1;
    cyc("t6_test");
    chk1("t6.test_de", intr_state_de_o, 1'b1);
    intr_test_qe_i = 1'b0;
    cyc("t6_test_off");
    chk1("t6.test_de_off", intr_state_de_o, 1'b0);
    intr_state_i = 1'b1; intr_enable_i = 1'b1; prescaler_i = 40;
    for (int i = 0; i < 5; i++) cyc("t6_run");
    prescaler_i = 3;
    #2 rst_ni = 1'b0;
    #1;
    m_cycles = 0; m_intr = 1'b0;
    chk1("t6.async_intr", intr_o, 1'b0);
    chk1("t6.async_tick", tick_o, 1'b0);
    cyc("t6_in_reset");
    rst_ni = 1'b1;
    intr_state_i = 1'b0; intr_enable_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc("t6_post");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      active_i       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) prescaler_i = PW'($urandom_range(0, 6));
      step_i         = SW'($urandom);
      mtime_i        = ($urandom_range(0, 15) == 0) ? '1 : {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: mtimecmp_i = mtime_i;
        1: mtimecmp_i = {$urandom, $urandom};
        default: mtimecmp_i = mtime_i + 64'd1;
      endcase
      intr_enable_i  = 1'($urandom);
      intr_state_i   = 1'($urandom);
      intr_test_qe_i = 1'($urandom);
      intr_test_q_i  = 1'($urandom);
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
